sa_conv3x3: RTL and testbench

Downstream consumer of the skewed three-row image streamer. Holds a stationary 3x3 signed kernel, takes the streamer's `srt_sig` and three row streams (row r aligned, row r+1 delayed 1 cycle, row r+2 delayed 2 cycles), and accumulates partial sums vertically through three pipelined row stages. It emits one fixed-point convolution result per valid window position, tagged with its row and column. It sits between the input streamer and the output/activation buffer.

---
 rtl/sa_pkg.sv | 16 +
 rtl/sa_row_pe.sv | 37 +++
 rtl/sa_conv3x3.sv | 194 +++++++++++++++++++
 tb/tb_sa_conv3x3.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and widths for the 3x3 stationary-kernel convolution engine.
package sa_pkg;

  localparam int ACC_W  = 36;
  localparam int PIX_W  = 16;
  localparam int TAPS   = 3;
  localparam int PROD_W = 2 * PIX_W;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY,
    RUN
  } state_t;

endpackage

// File: rtl/sa_row_pe.sv
// One kernel row: a two-deep tap shift register feeding a 3-term signed dot product.
module sa_row_pe
  import sa_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [PIX_W-1:0] x,
  input  logic signed [PIX_W-1:0] w0,
  input  logic signed [PIX_W-1:0] w1,
  input  logic signed [PIX_W-1:0] w2,
  output logic signed [ACC_W-1:0] dot
);

  logic signed [PIX_W-1:0]  tap1;
  logic signed [PIX_W-1:0]  tap2;
  logic signed [PROD_W-1:0] prod0;
  logic signed [PROD_W-1:0] prod1;
  logic signed [PROD_W-1:0] prod2;

  // Taps advance only on beats of this row, so skewed rows stay column-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap1 <= '0;
      tap2 <= '0;
    end else if (en) begin
      tap2 <= tap1;
      tap1 <= x;
    end
  end

  assign prod0 = PROD_W'(w0) * PROD_W'(tap2);
  assign prod1 = PROD_W'(w1) * PROD_W'(tap1);
  assign prod2 = PROD_W'(w2) * PROD_W'(x);
  assign dot   = ACC_W'(prod0) + ACC_W'(prod1) + ACC_W'(prod2);

endmodule

// File: rtl/sa_conv3x3.sv
// 3x3 convolution over skewed row streams with a vertically pipelined partial-sum chain.
// Define SA_CONV_SAT_EN to saturate the 16-bit result instead of wrapping it.
module sa_conv3x3
  import sa_pkg::*;
#(
  parameter int SIZE = 7,
  parameter int PAD  = 0,
  parameter int FRAC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  input  logic signed [PIX_W-1:0] w_in,
  input  logic                    srt_sig,
  input  logic signed [PIX_W-1:0] in1,
  input  logic signed [PIX_W-1:0] in2,
  input  logic signed [PIX_W-1:0] in3,
  output logic                    ready,
  output logic                    out_valid,
  output logic signed [PIX_W-1:0] out,
  output logic [7:0]              out_row,
  output logic [7:0]              out_col,
  output logic                    done
);

  localparam int         I_SIZE   = SIZE + 2 * PAD;
  localparam logic [7:0] COL_LAST = 8'(I_SIZE - 1);
  localparam logic [7:0] ROW_LAST = 8'(I_SIZE - 3);
  localparam logic [3:0] W_LAST   = 4'(TAPS * TAPS - 1);

  state_t                  state;
  state_t                  state_nx;
  logic signed [PIX_W-1:0] w [TAPS*TAPS];
  logic [3:0]              widx;
  logic [7:0]              row;
  logic [7:0]              col;
  logic                    beat;
  logic                    last;
  logic                    load_beat;
  logic                    restart;
  logic                    beat_d1;
  logic                    beat_d2;
  logic [2:0]              vld;
  logic [2:0]              done_p;
  logic [7:0]              row_s0, row_s1, row_s2;
  logic [7:0]              col_s0, col_s1, col_s2;
  logic signed [ACC_W-1:0] dot0, dot1, dot2;
  logic signed [ACC_W-1:0] p0, p1, p2;

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    beat      = 1'b0;
    load_beat = 1'b0;
    restart   = 1'b0;
    case (state)
      EMPTY: begin
        if (w_valid) begin
          load_beat = 1'b1;
          restart   = 1'b1;
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        if (w_valid) begin
          load_beat = 1'b1;
          if (widx == W_LAST) state_nx = READY;
        end
      end
      READY: begin
        if (w_valid) begin
          load_beat = 1'b1;
          restart   = 1'b1;
          state_nx  = LOAD;
        end else if (srt_sig) begin
          beat     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (srt_sig) begin
          beat = 1'b1;
          if (last) state_nx = READY;
        end else begin
          state_nx = READY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  assign ready = (state == READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS * TAPS; i++) w[i] <= '0;
      widx <= '0;
    end else if (load_beat) begin
      if (restart) begin
        w[0] <= w_in;
        widx <= 4'd1;
      end else begin
        w[widx] <= w_in;
        widx    <= widx + 4'd1;
      end
    end
  end

  // Any cycle that is not a mid-frame beat leaves the counters at the frame origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (beat && !last) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end else begin
      row <= '0;
      col <= '0;
    end
  end

  sa_row_pe u_pe0 (.clk(clk), .rst(rst), .en(beat),    .x(in1),
                   .w0(w[0]), .w1(w[1]), .w2(w[2]), .dot(dot0));
  sa_row_pe u_pe1 (.clk(clk), .rst(rst), .en(beat_d1), .x(in2),
                   .w0(w[3]), .w1(w[4]), .w2(w[5]), .dot(dot1));
  sa_row_pe u_pe2 (.clk(clk), .rst(rst), .en(beat_d2), .x(in3),
                   .w0(w[6]), .w1(w[7]), .w2(w[8]), .dot(dot2));

  // Valid is raised only once the taps hold a full window of the current row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_d1 <= 1'b0;
      beat_d2 <= 1'b0;
      vld     <= '0;
      done_p  <= '0;
      row_s0  <= '0;
      row_s1  <= '0;
      row_s2  <= '0;
      col_s0  <= '0;
      col_s1  <= '0;
      col_s2  <= '0;
      p0      <= '0;
      p1      <= '0;
      p2      <= '0;
    end else begin
      beat_d1 <= beat;
      beat_d2 <= beat_d1;
      vld     <= {vld[1:0], beat && (col >= 8'd2)};
      done_p  <= {done_p[1:0], beat && last};
      row_s0  <= row;
      row_s1  <= row_s0;
      row_s2  <= row_s1;
      col_s0  <= col - 8'd2;
      col_s1  <= col_s0;
      col_s2  <= col_s1;
      p0      <= dot0;
      p1      <= p0 + dot1;
      p2      <= p1 + dot2;
    end
  end

  assign out_valid = vld[2];
  assign done      = done_p[2];
  assign out_row   = row_s2;
  assign out_col   = col_s2;

`ifdef SA_CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;
  logic signed [ACC_W-1:0] shifted;

  assign shifted = p2 >>> FRAC;

  always_comb begin
    out = PIX_W'(shifted);
    if (shifted > SAT_MAX)      out = 16'sh7fff;
    else if (shifted < SAT_MIN) out = 16'sh8000;
  end
`else
  assign out = PIX_W'(p2 >>> FRAC);
`endif

endmodule

// File: tb/tb_sa_conv3x3.sv
// Directed bench for sa_conv3x3: a 4x4 FRAC=8 instance plus a FRAC=0 instance driven to overflow.
module tb_sa_conv3x3;

  localparam int I_SIZE = 4;
  localparam int FRAC   = 8;
`ifdef SA_CONV_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7fff;
`else
  localparam logic [15:0] SAT_EXP = 16'h0009;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_valid = 1'b0;
  logic        srt_sig = 1'b0;
  logic [15:0] w_in = '0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [15:0] in3 = '0;
  logic        ready, out_valid, done;
  logic [15:0] out;
  logic [7:0]  out_row, out_col;
  logic        s_ready, s_out_valid, s_done;
  logic [15:0] s_out;
  logic [7:0]  s_out_row, s_out_col;

  int          checks = 0;
  int          failures = 0;
  int          kern [9];
  int          n_res, done_cnt, first_k;
  logic [15:0] res_val [16];
  logic [7:0]  res_row [16];
  logic [7:0]  res_col [16];
  logic        res_done [16];
  logic [15:0] sat_val [16];
  logic        sat_vld [16];
  logic [15:0] hand_exp [4];
  bit          use_hand;

  always #5 clk = ~clk;

  sa_conv3x3 #(.SIZE(4), .PAD(0), .FRAC(FRAC)) u_dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_in(w_in), .srt_sig(srt_sig),
    .in1(in1), .in2(in2), .in3(in3), .ready(ready), .out_valid(out_valid),
    .out(out), .out_row(out_row), .out_col(out_col), .done(done)
  );

  sa_conv3x3 #(.SIZE(4), .PAD(0), .FRAC(0)) u_sat (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_in(16'h7fff), .srt_sig(srt_sig),
    .in1(16'h7fff), .in2(16'h7fff), .in3(16'h7fff), .ready(s_ready),
    .out_valid(s_out_valid), .out(s_out), .out_row(s_out_row), .out_col(s_out_col),
    .done(s_done)
  );

  function automatic int pix(int r, int c, int mode);
    case (mode)
      0:       return 10 * r + c;
      1:       return 1;
      default: return 7 * r + 3 * c - 20;
    endcase
  endfunction

  function automatic logic [15:0] model(int orow, int ocol, int mode);
    longint acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += longint'(kern[i*3+j]) * longint'(pix(orow + i, ocol + j, mode));
    acc = acc >>> FRAC;
`ifdef SA_CONV_SAT_EN
    if (acc > 32767)       acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return 16'(acc);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives cycle k of a frame: row r on in1 now, rows r+1 and r+2 one and two cycles later.
  task automatic applyStimulus(input int k, input int nbeats, input int mode, input bit wpulse);
    srt_sig = (k < nbeats);
    in1 = (k < nbeats) ? 16'(pix(k / I_SIZE, k % I_SIZE, mode)) : '0;
    in2 = (k >= 1 && k - 1 < nbeats) ? 16'(pix((k - 1) / I_SIZE + 1, (k - 1) % I_SIZE, mode)) : '0;
    in3 = (k >= 2 && k - 2 < nbeats) ? 16'(pix((k - 2) / I_SIZE + 2, (k - 2) % I_SIZE, mode)) : '0;
    w_valid = wpulse && (k < nbeats) && (k % 3 == 1);
    w_in = 16'h7f00;
  endtask

  task automatic loadKernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 5) begin
        w_valid = 1'b0;
        @(negedge clk);
      end
      if (i == 8) checkOutput("ready_before_last_beat", 64'(ready), 64'(0));
      w_valid = 1'b1;
      w_in    = 16'(kern[i]);
    end
    @(negedge clk);
    w_valid = 1'b0;
    checkOutput("ready_after_load", 64'(ready), 64'(1));
  endtask

  task automatic runFrame(input int nbeats, input int mode, input int rst_at, input bit wpulse);
    n_res = 0;
    done_cnt = 0;
    first_k = -1;
    for (int i = 0; i < 16; i++) begin
      res_val[i] = 'x;
      res_row[i] = 'x;
      res_col[i] = 'x;
      res_done[i] = 1'bx;
      sat_val[i] = 'x;
      sat_vld[i] = 1'bx;
    end
    for (int k = 0; k < nbeats + 5; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        if (n_res < 16) begin
          res_val[n_res]  = out;
          res_row[n_res]  = out_row;
          res_col[n_res]  = out_col;
          res_done[n_res] = done;
          sat_val[n_res]  = s_out;
          sat_vld[n_res]  = s_out_valid;
        end
        n_res++;
      end
      if (done === 1'b1) done_cnt++;
      if (k == rst_at) begin
        rst = 1'b1;
        srt_sig = 1'b0;
        w_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        in3 = '0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out", 64'(out), 64'(0));
        checkOutput("rst_ready", 64'(ready), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_out_col", 64'(out_col), 64'(0));
        return;
      end
      applyStimulus(k, nbeats, mode, wpulse);
    end
  endtask

  task automatic checkResults(input string name, input int nexp, input int mode, input int ndone);
    checkOutput({name, "_count"}, 64'(n_res), 64'(nexp));
    for (int i = 0; i < nexp; i++) begin
      checkOutput($sformatf("%s_val%0d", name, i), 64'(res_val[i]),
                  64'(use_hand ? hand_exp[i] : model(i / 2, i % 2, mode)));
      checkOutput($sformatf("%s_row%0d", name, i), 64'(res_row[i]), 64'(i / 2));
      checkOutput($sformatf("%s_col%0d", name, i), 64'(res_col[i]), 64'(i % 2));
    end
    checkOutput({name, "_done_count"}, 64'(done_cnt), 64'(ndone));
    if (ndone > 0) checkOutput({name, "_done_on_last"}, 64'(res_done[nexp-1]), 64'(1));
    checkOutput({name, "_ready_after"}, 64'(ready), 64'(1));
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 64'(ready), 64'(0));
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_out", 64'(out), 64'(0));
    checkOutput("reset_out_row", 64'(out_row), 64'(0));
    checkOutput("reset_out_col", 64'(out_col), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    rst = 1'b0;

    // Stream before any kernel is loaded must be ignored.
    runFrame(8, 0, -1, 1'b0);
    checkOutput("empty_no_results", 64'(n_res), 64'(0));
    checkOutput("empty_ready", 64'(ready), 64'(0));

    // Identity kernel, plus the overflowing FRAC=0 instance alongside.
    kern = '{0, 0, 0, 0, 256, 0, 0, 0, 0};
    loadKernel();
    runFrame(8, 0, -1, 1'b0);
    hand_exp = '{16'd11, 16'd12, 16'd21, 16'd22};
    use_hand = 1'b1;
    checkResults("identity", 4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sat_valid%0d", i), 64'(sat_vld[i]), 64'(1));
      checkOutput($sformatf("sat_val%0d", i), 64'(sat_val[i]), 64'(SAT_EXP));
    end

    // All-ones kernel and image; first result three cycles after the third beat.
    kern = '{256, 256, 256, 256, 256, 256, 256, 256, 256};
    loadKernel();
    runFrame(8, 1, -1, 1'b0);
    hand_exp = '{16'd9, 16'd9, 16'd9, 16'd9};
    checkResults("ones", 4, 1, 1);
    checkOutput("ones_first_latency", 64'(first_k - 2), 64'(3));

    // Signed kernel with kernel beats injected mid-run.
    kern = '{-256, 128, 0, 512, -384, 64, 0, 256, -128};
    loadKernel();
    use_hand = 1'b0;
    runFrame(8, 2, -1, 1'b1);
    checkResults("ignored_w", 4, 2, 1);

    // Stream drops after three beats of row 1; in-flight results drain without done.
    runFrame(7, 2, -1, 1'b0);
    checkResults("interrupt", 3, 2, 0);
    runFrame(8, 2, -1, 1'b0);
    checkResults("fresh", 4, 2, 1);

    // Reset in the middle of a frame, then stream ignored until a new kernel arrives.
    runFrame(8, 2, 5, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runFrame(8, 0, -1, 1'b0);
    checkOutput("post_rst_no_results", 64'(n_res), 64'(0));
    checkOutput("post_rst_ready", 64'(ready), 64'(0));
    kern = '{0, 0, 0, 0, 256, 0, 0, 0, 0};
    loadKernel();
    runFrame(8, 0, -1, 1'b0);
    hand_exp = '{16'd11, 16'd12, 16'd21, 16'd22};
    use_hand = 1'b1;
    checkResults("reload", 4, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
